// File: rtl/iir1_inverse_fir.sv
// Inverse filter for y(n)=b*x(n)+a*y(n-1): recovers x(n)=C0*y(n)+C1*y(n-1).
// Four-stage valid/ready pipeline (capture, multiply, product register, sum/clamp).
module iir1_inverse_fir #(
  parameter int                 Y_W   = 17,
  parameter int                 X_W   = 8,
  parameter logic signed [15:0] C0    = -16'sd1,
  parameter logic signed [15:0] C1    = 16'sd1,
  parameter int                 SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic signed [Y_W-1:0] in_y,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic signed [X_W-1:0] out_x,
  input  logic                  out_ready,
  output logic                  sat
);

  localparam int P_W = Y_W + 16;
  localparam int S_W = Y_W + 17;
  localparam logic signed [S_W-1:0] MAX_V = S_W'((2 ** (X_W - 1)) - 1);
  localparam logic signed [S_W-1:0] MIN_V = S_W'(-(2 ** (X_W - 1)));

  typedef enum logic {PRIME, RUN} state_t;

  state_t                state;
  logic signed [Y_W-1:0] hist;

  logic                  s0_valid, m1_valid, m2_valid;
  logic signed [Y_W-1:0] s0_y, s0_yprev;
  logic signed [P_W-1:0] m1_p0, m1_p1, m2_p0, m2_p1;

  logic                  adv, accept;
  logic signed [P_W-1:0] prod0, prod1;
  logic signed [S_W-1:0] sum, shifted;
  logic                  clip_hi, clip_lo;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  assign prod0 = $signed({{16{s0_y[Y_W-1]}}, s0_y}) * $signed({{Y_W{C0[15]}}, C0});
  assign prod1 = $signed({{16{s0_yprev[Y_W-1]}}, s0_yprev}) * $signed({{Y_W{C1[15]}}, C1});

  // Full-width sum; arithmetic shift floors toward -inf before clamping.
  assign sum     = $signed({m2_p0[P_W-1], m2_p0}) + $signed({m2_p1[P_W-1], m2_p1});
  assign shifted = sum >>> SHIFT;
  assign clip_hi = shifted > MAX_V;
  assign clip_lo = shifted < MIN_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRIME;
      hist      <= '0;
      s0_valid  <= 1'b0;
      s0_y      <= '0;
      s0_yprev  <= '0;
      m1_valid  <= 1'b0;
      m1_p0     <= '0;
      m1_p1     <= '0;
      m2_valid  <= 1'b0;
      m2_p0     <= '0;
      m2_p1     <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      sat       <= 1'b0;
    end else begin
      if (adv) begin
        s0_valid <= accept;
        if (accept) begin
          s0_y     <= in_y;
          s0_yprev <= (state == PRIME || clear) ? '0 : hist;
        end
        m1_valid  <= s0_valid;
        m1_p0     <= prod0;
        m1_p1     <= prod1;
        m2_valid  <= m1_valid;
        m2_p0     <= m1_p0;
        m2_p1     <= m1_p1;
        out_valid <= m2_valid;
        // out_x/sat keep their last value across bubbles.
        if (m2_valid) begin
          out_x <= clip_hi ? MAX_V[X_W-1:0] : clip_lo ? MIN_V[X_W-1:0] : shifted[X_W-1:0];
          sat   <= clip_hi | clip_lo;
        end
      end
      if (accept) begin
        hist  <= in_y;
        state <= RUN;
      end else if (clear) begin
        state <= PRIME;
      end
    end
  end

endmodule

// File: tb/tb_iir1_inverse_fir.sv
// Directed bench for iir1_inverse_fir with default coefficients (a=1, b=-1).
// Stepping happens one clock at a time; outputs are checked 1ns after each rising edge.
module tb_iir1_inverse_fir;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [16:0] in_y = '0;
  logic               in_ready;
  logic               out_valid;
  logic signed [7:0]  out_x;
  logic               out_ready = 1'b1;
  logic               sat;

  int n_chk = 0;
  int n_fail = 0;

  iir1_inverse_fir dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_y(in_y), .in_ready(in_ready),
    .out_valid(out_valid), .out_x(out_x), .out_ready(out_ready), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int exp_x, input logic exp_sat);
    chk({tag, "_valid"}, 32'(out_valid), 32'sd1);
    chk({tag, "_x"}, 32'(out_x), exp_x);
    chk({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    $display("step %-10s out_valid=%0d out_x=%0d sat=%0d", tag, out_valid, out_x, sat);
  endtask

  task automatic cyc(input logic v, input int y, input logic clr, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_y      = 17'(y);
    clear     = clr;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic push(input int y);
    cyc(1'b1, y, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'sd0);
    chk("rst_x", 32'(out_x), 32'sd0);
    chk("rst_sat", 32'(sat), 32'sd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: back-to-back after reset, 3-edge latency
    push(-3);
    push(-8);
    push(-6);
    idle(); expect_out("t1_a", 3, 1'b0);
    chk("t1_in_ready", 32'(in_ready), 32'sd1);
    idle(); expect_out("t1_b", 5, 1'b0);
    idle(); expect_out("t1_c", -2, 1'b0);
    idle();
    chk("t1_bubble", 32'(out_valid), 32'sd0);
    chk("t1_hold_x", 32'(out_x), -32'sd2);

    // 2: round trip of x=3,5,-2,0,7 through y=-x+y(n-1)
    cyc(1'b0, 0, 1'b1, 1'b1);
    push(-3);
    push(-8);
    push(-6);
    push(-6);  expect_out("t2_a", 3, 1'b0);
    push(-13); expect_out("t2_b", 5, 1'b0);
    idle();    expect_out("t2_c", -2, 1'b0);
    idle();    expect_out("t2_d", 0, 1'b0);
    idle();    expect_out("t2_e", 7, 1'b0);

    // 3: saturation both ways
    cyc(1'b0, 0, 1'b1, 1'b1);
    push(-200);
    push(100);
    idle();
    idle(); expect_out("t3_hi", 127, 1'b1);
    idle(); expect_out("t3_lo", -128, 1'b1);

    // 4: backpressure, x=1..6
    cyc(1'b0, 0, 1'b1, 1'b1);
    push(-1);
    push(-3);
    push(-6);
    push(-10); expect_out("t4_1", 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, -15, 1'b0, 1'b0);
      expect_out("t4_stall", 1, 1'b0);
      chk("t4_in_ready", 32'(in_ready), 32'sd0);
    end
    push(-15); expect_out("t4_2", 2, 1'b0);
    push(-21); expect_out("t4_3", 3, 1'b0);
    idle();    expect_out("t4_4", 4, 1'b0);
    idle();    expect_out("t4_5", 5, 1'b0);
    idle();    expect_out("t4_6", 6, 1'b0);
    idle();
    chk("t4_drain", 32'(out_valid), 32'sd0);

    // 5: clear together with an accept
    cyc(1'b0, 0, 1'b1, 1'b1);
    push(-3);
    push(-8);
    cyc(1'b1, -6, 1'b1, 1'b1);
    push(-6); expect_out("t5_a", 3, 1'b0);
    idle();   expect_out("t5_b", 5, 1'b0);
    idle();   expect_out("t5_c", 6, 1'b0);
    idle();   expect_out("t5_d", 0, 1'b0);

    // 6: reset with samples in flight
    cyc(1'b0, 0, 1'b1, 1'b1);
    push(-3);
    push(-8);
    push(-6);
    push(-6); expect_out("t6_pre", 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'sd0);
    chk("t6_rst_x", 32'(out_x), 32'sd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t6_flushed", 32'(out_valid), 32'sd0);
    end
    push(-4);
    idle();
    idle();
    idle(); expect_out("t6_post", 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
